alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 8, width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; request i accepted when req_valid[i] && req_ready[i] at a rising edge.
REQ-006 req_a  input  8  operand A, requester i in bits [4i+3:4i].
REQ-007 req_b  input  8  operand B, same packing as req_a.
REQ-008 req_op  input  6  3-bit opcode, requester i in bits [3i+2:3i].
REQ-009 rsp_valid  output  1  response valid.
REQ-010 rsp_ready  input  1  response consumer accept.
REQ-011 rsp_result  output  4  ALU result.
REQ-012 rsp_id  output  1  index of the requester that owns the response.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done_cnt  output  CNT_W  count of completed responses.

Function
REQ-015 Opcodes SHALL be: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 ~A, 110 A<<1, 111 A>>1 (logical); all results truncated modulo 16.
REQ-016 FSM SHALL have states IDLE, EXEC, RESP; reset state IDLE.
REQ-017 In IDLE, req_ready SHALL be high only for the granted requester; outside IDLE req_ready SHALL be 00.
REQ-018 Grant: single valid requester wins; both valid -> requester not granted last (round-robin); last-grant pointer resets to 1, so requester 0 wins the first contention.
REQ-019 On accept, A, B, OP and requester index SHALL be latched; IDLE -> EXEC.
REQ-020 EXEC SHALL register the ALU output into rsp_result, set rsp_valid, go to RESP; rsp_valid is high the second cycle after the accept edge (latency 2 edges).
REQ-021 RESP SHALL hold rsp_valid, rsp_result, rsp_id stable until rsp_ready; on rsp_valid && rsp_ready -> IDLE, rsp_valid cleared, done_cnt incremented.
REQ-022 done_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-023 A new request SHALL NOT be accepted in the same cycle as a response handshake; peak throughput one operation per 3 cycles.
REQ-024 Requests deasserted before acceptance SHALL be dropped with no side effect; req_valid changes outside IDLE SHALL be ignored.
REQ-025 Last-grant pointer SHALL update only on an accept.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, req_ready 00, rsp_valid 0, rsp_result 0, rsp_id 0, busy 0, done_cnt 0, last-grant pointer 1.
REQ-027 Reset in EXEC or RESP SHALL discard the in-flight operation without producing a response or counting it.
REQ-028 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 Package alu_pkg SHALL hold the opcode constants and the FSM state type.
REQ-030 Combinational ALU SHALL be a sub-module alu_core (A, B, OP -> Result), instantiated once; alu_arbiter holds all sequential logic.

Verification
REQ-031 Requester 0: A=0010, B=0101, OP=000 -> rsp_result 0111, rsp_id 0, rsp_valid 2 edges after accept, done_cnt 1.
REQ-032 Requester 1: A=0101, B=0010, OP=001 -> 0011; then A=0010, B=0101, OP=001 -> 1101; A=1001, B=1000, OP=000 -> 0001 (wrap).
REQ-033 Both requesters held valid continuously for 4 operations -> rsp_id sequence 0,1,0,1; req_ready never 11.
REQ-034 rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_result, rsp_id stable, req_ready 00, busy 1; release -> IDLE next edge.
REQ-035 rst_n pulsed low during EXEC -> no response, done_cnt 0, rsp_valid 0, next request served normally with requester 0 winning contention.
REQ-036 OP sweep 010..111 with A=1100, B=1010 -> 1000, 1110, 0110, 0011, 1000, 0110.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
package alu_pkg;

    localparam int unsigned DataW  = 4;
    localparam int unsigned OpW    = 3;
    localparam int unsigned NumReq = 2;

    // ALU opcodes
    localparam logic [OpW-1:0] OpAdd = 3'b000;
    localparam logic [OpW-1:0] OpSub = 3'b001;
    localparam logic [OpW-1:0] OpAnd = 3'b010;
    localparam logic [OpW-1:0] OpOr  = 3'b011;
    localparam logic [OpW-1:0] OpXor = 3'b100;
    localparam logic [OpW-1:0] OpNot = 3'b101;
    localparam logic [OpW-1:0] OpShl = 3'b110;
    localparam logic [OpW-1:0] OpShr = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    // One-hot grant: a lone requester wins; on contention the one not granted last wins.
    function automatic logic [NumReq-1:0] rr_grant(logic [NumReq-1:0] valid, logic last);
        logic [NumReq-1:0] grant;
        grant = '0;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 4-bit ALU; every result is truncated to DataW bits.
module alu_core
    import alu_pkg::*;
(
    input  logic [DataW-1:0] a,
    input  logic [DataW-1:0] b,
    input  logic [OpW-1:0]   op,
    output logic [DataW-1:0] result
);

    // Opcode decode
    always_comb begin
        result = '0;
        unique case (op)
            OpAdd:   result = a + b;
            OpSub:   result = a - b;
            OpAnd:   result = a & b;
            OpOr:    result = a | b;
            OpXor:   result = a ^ b;
            OpNot:   result = ~a;
            OpShl:   result = a << 1;
            OpShr:   result = a >> 1;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a shared ALU: accept one request, compute, hold the
// response until consumed, then return to idle.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NumReq-1:0]        req_valid,
    output logic [NumReq-1:0]        req_ready,
    input  logic [NumReq*DataW-1:0]  req_a,
    input  logic [NumReq*DataW-1:0]  req_b,
    input  logic [NumReq*OpW-1:0]    req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DataW-1:0]         rsp_result,
    output logic                     rsp_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         done_cnt
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e             state_q, state_d;
    logic               last_q;
    logic [DataW-1:0]   a_q, b_q;
    logic [OpW-1:0]     op_q;
    logic               id_q;
    logic               rsp_valid_q;
    logic [DataW-1:0]   rsp_result_q;
    logic               rsp_id_q;
    logic [CNT_W-1:0]   done_cnt_q;

    logic [NumReq-1:0]  grant;
    logic               grant_idx;
    logic               accept;
    logic               rsp_hs;
    logic [DataW-1:0]   alu_res;

    // Arbitration and handshake decode
    always_comb begin
        grant     = rr_grant(req_valid, last_q);
        grant_idx = grant[1];
        accept    = (state_q == StIdle) && (|grant);
        rsp_hs    = (state_q == StResp) && rsp_valid_q && rsp_ready;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; req_ready is gated by reset so it reads 00 the moment rst_n falls
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == StIdle)) begin
            req_ready = grant;
        end
        busy       = (state_q != StIdle);
        rsp_valid  = rsp_valid_q;
        rsp_result = rsp_result_q;
        rsp_id     = rsp_id_q;
        done_cnt   = done_cnt_q;
    end

    // Operand capture and last-grant pointer, both updated only on an accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            id_q   <= 1'b0;
            last_q <= 1'b1;
        end else if (accept) begin
            a_q    <= grant_idx ? req_a[2*DataW-1:DataW] : req_a[DataW-1:0];
            b_q    <= grant_idx ? req_b[2*DataW-1:DataW] : req_b[DataW-1:0];
            op_q   <= grant_idx ? req_op[2*OpW-1:OpW]    : req_op[OpW-1:0];
            id_q   <= grant_idx;
            last_q <= grant_idx;
        end
    end

    // Response registers: loaded in EXEC, held through RESP until the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
        end else if (state_q == StExec) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= alu_res;
            rsp_id_q     <= id_q;
        end else if (rsp_hs) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    // Completed-operation counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_q <= '0;
        end else if (rsp_hs) begin
            done_cnt_q <= done_cnt_q + CntOne;
        end
    end

    alu_core u_alu_core (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_res)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a response scoreboard.
module tb_alu_arbiter;

    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        logic       id;
        logic [3:0] res;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [7:0]       req_a;
    logic [7:0]       req_b;
    logic [5:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_result;
    logic             rsp_id;
    logic             busy;
    logic [CNT_W-1:0] done_cnt;

    int               checks = 0;
    int               errors = 0;
    exp_t             sb[$];
    logic [CNT_W-1:0] tb_done = '0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    task automatic push_exp(input logic id, input logic [3:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        sb.push_back(e);
    endtask

    task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] op);
        req_a[id*4 +: 4]  = a;
        req_b[id*4 +: 4]  = b;
        req_op[id*3 +: 3] = op;
    endtask

    // Drive one request, wait for its accept, leave time #1 after the accept edge
    task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic [3:0] exp_res);
        bit ok;
        logic [1:0] want;
        ok   = 1'b0;
        want = 2'b01 << id;
        set_req(id, a, b, op);
        req_valid[id] = 1'b1;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (req_ready !== 2'b00) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok || req_ready !== want) begin
            errors++;
            $display("FAIL accept_req%0d: req_ready=%b, required %b", id, req_ready, want);
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        if (ok) push_exp(id[0], exp_res);
    endtask

    // Wait for the response, compare to scoreboard, optionally hold off, then consume it
    task automatic collect(input int hold, input bit stress);
        int n;
        exp_t e;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                n = k;
                break;
            end
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL rsp_latency: rsp_valid after %0d cycles, required 2", n);
        end
        if (n == 0) return;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: unexpected response id=%0d result=%b, required none",
                     rsp_id, rsp_result);
            return;
        end
        e = sb.pop_front();
        if (rsp_result !== e.res) begin
            errors++;
            $display("FAIL rsp_result: got %b, required %b", rsp_result, e.res);
        end
        checks++;
        if (rsp_id !== e.id) begin
            errors++;
            $display("FAIL rsp_id: got %0d, required %0d", rsp_id, e.id);
        end
        if (stress) req_valid = 2'b11;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== e.res || rsp_id !== e.id ||
                req_ready !== 2'b00 || busy !== 1'b1) begin
                errors++;
                $display("FAIL rsp_hold: valid=%b result=%b id=%b req_ready=%b busy=%b, required 1 %b %b 00 1",
                         rsp_valid, rsp_result, rsp_id, req_ready, busy, e.res, e.id);
            end
        end
        if (stress) req_valid = 2'b00;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        tb_done = tb_done + 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rsp_release: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
        end
        checks++;
        if (done_cnt !== tb_done) begin
            errors++;
            $display("FAIL done_cnt: got %0d, required %0d", done_cnt, tb_done);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        set_req(0, 4'b0010, 4'b0101, 3'b000);
        req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req_ready=%b busy=%b rsp_valid=%b, required 00 0 0",
                     req_ready, busy, rsp_valid);
        end
        checks++;
        if (rsp_result !== 4'b0000 || rsp_id !== 1'b0 || done_cnt !== '0) begin
            errors++;
            $display("FAIL reset_data: rsp_result=%b rsp_id=%b done_cnt=%0d, required 0000 0 0",
                     rsp_result, rsp_id, done_cnt);
        end
    endtask

    // Request already waiting at reset release must be taken on the first edge
    task automatic test_first_accept;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_accept: busy=%b after first edge, required 1", busy);
        end
        push_exp(1'b0, 4'b0111);
        collect(0, 1'b0);
    endtask

    task automatic test_req1_ops;
        issue(1, 4'b0101, 4'b0010, 3'b001, 4'b0011);
        collect(0, 1'b0);
        issue(1, 4'b0010, 4'b0101, 3'b001, 4'b1101);
        collect(0, 1'b0);
        issue(1, 4'b1001, 4'b1000, 3'b000, 4'b0001);
        collect(0, 1'b0);
    endtask

    task automatic test_op_sweep;
        logic [3:0] exp_tab [6];
        exp_tab = '{4'b1000, 4'b1110, 4'b0110, 4'b0011, 4'b1000, 4'b0110};
        for (int i = 0; i < 6; i++) begin
            issue(0, 4'b1100, 4'b1010, 3'(i + 2), exp_tab[i]);
            collect(0, 1'b0);
        end
    endtask

    task automatic test_backpressure;
        issue(1, 4'b0011, 4'b0100, 3'b000, 4'b0111);
        collect(5, 1'b1);
    endtask

    // Both requesters valid the whole time; last grant went to requester 1 before this
    task automatic test_round_robin;
        int order [4];
        logic [3:0] res_tab [2];
        logic [1:0] want;
        order   = '{0, 1, 0, 1};
        res_tab = '{4'b0011, 4'b0101};
        set_req(0, 4'b0110, 4'b0011, 3'b001);
        set_req(1, 4'b0100, 4'b0001, 3'b011);
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 20 && req_ready === 2'b00; k++) @(negedge clk);
            want = 2'b01 << order[i];
            checks++;
            if (req_ready !== want) begin
                errors++;
                $display("FAIL rr_grant%0d: req_ready=%b, required %b", i, req_ready, want);
            end
            @(posedge clk);
            #1;
            push_exp(order[i][0], res_tab[order[i]]);
            collect(0, 1'b0);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 8 && tb_done !== '1; i++) begin
            issue(0, 4'b0001, 4'b0010, 3'b000, 4'b0011);
            collect(0, 1'b0);
        end
        issue(1, 4'b1111, 4'b0001, 3'b000, 4'b0000);
        collect(0, 1'b0);
        checks++;
        if (done_cnt !== '0) begin
            errors++;
            $display("FAIL done_wrap: done_cnt=%0d, required 0", done_cnt);
        end
    endtask

    task automatic test_reset_in_exec;
        bit seen;
        issue(0, 4'b0001, 4'b0001, 3'b000, 4'b0010);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL exec_reset_ctrl: busy=%b rsp_valid=%b req_ready=%b, required 0 0 00",
                     busy, rsp_valid, req_ready);
        end
        checks++;
        if (done_cnt !== '0 || rsp_result !== 4'b0000 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL exec_reset_data: done_cnt=%0d rsp_result=%b rsp_id=%b, required 0 0000 0",
                     done_cnt, rsp_result, rsp_id);
        end
        sb.delete();
        tb_done = '0;
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || done_cnt !== '0) begin
            errors++;
            $display("FAIL exec_reset_drop: response or activity seen=%b done_cnt=%0d, required 0 0",
                     seen, done_cnt);
        end
        set_req(0, 4'b0010, 4'b0101, 3'b000);
        set_req(1, 4'b0001, 4'b0001, 3'b000);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_grant: req_ready=%b, required 01", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        push_exp(1'b0, 4'b0111);
        collect(0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_req1_ops();
        test_op_sweep();
        test_backpressure();
        test_round_robin();
        test_wrap();
        test_reset_in_exec();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
